// File: rtl/bk_addsub_pipe.sv
// bk_addsub_pipe: 3-stage pipelined Brent-Kung add/subtract unit.
//   {cout,s} = a + (sub ? ~b : b) + (sub ? ~cin : cin); ovf flags signed overflow.
//   Stage 1 registers bitwise generate/propagate, stage 2 the up-sweep group
//   terms, stage 3 (output) the down-sweep carries and final sum.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   operand handshake (a, b, cin, sub)
//   out_valid/ready  result handshake (s, cout, ovf)
// The whole pipe advances together; a stalled output freezes every stage.
module bk_addsub_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned LOG = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  logic             en;
  logic             v1, v2, v3;

  // stage 1 registers
  logic [WIDTH-1:0] g1, p1;
  logic             c0_1, am1, bm1;

  // stage 2 registers
  logic [WIDTH-1:0] gg2, gp2, p2;
  logic             c0_2, am2, bm2;

  // stage 1 combinational
  logic [WIDTH-1:0] bb_c;
  logic             c0_c;

  // stage 3 combinational
  logic [WIDTH-1:0] gf_c, pf_c, s_c;
  logic [WIDTH:0]   carry_c;
  logic             cout_c, ovf_c;

  // Global stall: everything moves only when the output slot is free or drained.
  assign en        = !v3 || out_ready;
  assign in_ready  = en;
  assign out_valid = v3;

  // Subtract is a + ~b + ~borrow.
  assign bb_c = sub ? ~b : b;
  assign c0_c = sub ? ~cin : cin;

  // Up-sweep: level l combines node i with node i-2^l where i+1 is a multiple of 2^(l+1).
  for (genvar l = 0; l < LOG; l++) begin : g_up
    logic [WIDTH-1:0] gi, pi, go, po;
    if (l == 0) begin : g_src
      assign gi = g1;
      assign pi = p1;
    end else begin : g_chain
      assign gi = g_up[l-1].go;
      assign pi = g_up[l-1].po;
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i + 1) % (2 << l)) == 0) begin : g_node
        assign go[i] = gi[i] | (pi[i] & gi[i - (1 << l)]);
        assign po[i] = pi[i] & pi[i - (1 << l)];
      end else begin : g_pass
        assign go[i] = gi[i];
        assign po[i] = pi[i];
      end
    end
  end

  // Down-sweep: fills the remaining prefixes from the widest span down to span 1.
  for (genvar k = 0; k < int'(LOG) - 1; k++) begin : g_dn
    localparam int STEP = 1 << (int'(LOG) - 2 - k);
    logic [WIDTH-1:0] gi, pi, go, po;
    if (k == 0) begin : g_src
      assign gi = gg2;
      assign pi = gp2;
    end else begin : g_chain
      assign gi = g_dn[k-1].go;
      assign pi = g_dn[k-1].po;
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if ((((i + 1) % (2 * STEP)) == STEP) && (i > STEP)) begin : g_node
        assign go[i] = gi[i] | (pi[i] & gi[i - STEP]);
        assign po[i] = pi[i] & pi[i - STEP];
      end else begin : g_pass
        assign go[i] = gi[i];
        assign po[i] = pi[i];
      end
    end
  end

  // Full prefixes G[i:0]/P[i:0]; carry into bit i+1 folds in c0.
  assign gf_c    = g_dn[int'(LOG) - 2].go;
  assign pf_c    = g_dn[int'(LOG) - 2].po;
  assign carry_c = {gf_c | (pf_c & {WIDTH{c0_2}}), c0_2};
  assign s_c     = p2 ^ carry_c[WIDTH-1:0];
  assign cout_c  = carry_c[WIDTH];
  assign ovf_c   = (am2 == bm2) && (s_c[MSB] != am2);

  // Pipeline registers: all stages shift together when en, hold otherwise.
  always_ff @(posedge clk) begin : pipe_regs
    if (rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      g1   <= '0;
      p1   <= '0;
      c0_1 <= 1'b0;
      am1  <= 1'b0;
      bm1  <= 1'b0;
      gg2  <= '0;
      gp2  <= '0;
      p2   <= '0;
      c0_2 <= 1'b0;
      am2  <= 1'b0;
      bm2  <= 1'b0;
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (en) begin
      v1   <= in_valid;
      v2   <= v1;
      v3   <= v2;
      g1   <= a & bb_c;
      p1   <= a ^ bb_c;
      c0_1 <= c0_c;
      am1  <= a[MSB];
      bm1  <= bb_c[MSB];
      gg2  <= g_up[LOG-1].go;
      gp2  <= g_up[LOG-1].po;
      p2   <= p1;
      c0_2 <= c0_1;
      am2  <= am1;
      bm2  <= bm1;
      s    <= s_c;
      cout <= cout_c;
      ovf  <= ovf_c;
    end
  end

endmodule

// File: tb/tb_bk_addsub_pipe.sv
// tb_bk_addsub_pipe: scoreboard bench for bk_addsub_pipe.
// Expected results come from integer arithmetic on 64-bit values.
module tb_bk_addsub_pipe;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, s;

  always #5 clk = ~clk;

  bk_addsub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  res_t        sb[$];
  int unsigned deliv_cyc[$];
  int          compared   = 0;
  int          mismatched = 0;
  int unsigned cyc        = 0;
  logic        rand_ready = 1'b0;
  res_t        held, exp_r;
  logic        held_v     = 1'b0;

  logic [W-1:0] corners [12] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 32'h7FFF_FFFF,
                                 32'h8000_0000, 32'h8000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                                 32'h5555_5555, 32'hAAAA_AAAA, 32'h0000_FFFF, 32'hFFFF_0000};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: plain integer add/subtract, signed range check for ovf.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic op_sub);
    res_t   r;
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint c  = longint'(ci);
    longint ures, sres;
    if (op_sub) begin
      ures   = ux - uy - c;
      sres   = sx - sy - c;
      r.cout = (ures >= 0);
    end else begin
      ures   = ux + uy + c;
      sres   = sx + sy + c;
      r.cout = (ures >= 64'sd4294967296);
    end
    r.s   = W'(ures);
    r.ovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 11)];
    return $urandom;
  endfunction

  // Monitor: pops the scoreboard on every delivered beat; checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'({s, cout, ovf}), 64'(held));
      end
      if (out_valid && !out_ready) begin
        held   = {s, cout, ovf};
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        deliv_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_beat: actual s=0x%0h cout=%0b required no beat", s, cout);
        end else begin
          exp_r = sb.pop_front();
          check("result", 64'({s, cout, ovf}), 64'(exp_r));
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Present one beat until accepted (bounded), then push its expected result.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic op_sub, input res_t req);
    logic acc = 1'b0;
    int   k   = 0;
    a = x; b = y; cin = ci; sub = op_sub; in_valid = 1'b1;
    while (!acc && k < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      k++;
    end
    in_valid = 1'b0;
    if (acc) sb.push_back(req);
    else check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_rand();
    logic [W-1:0] x = pick();
    logic [W-1:0] y = pick();
    logic         ci = 1'($urandom_range(0, 1));
    logic         op = 1'($urandom_range(0, 1));
    send(x, y, ci, op, model(x, y, ci, op));
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Single beat into an empty pipe: result must show after two more edges.
  task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic op_sub, input res_t req);
    int k = 0;
    send(x, y, ci, op_sub, req);
    while (!out_valid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("latency", 64'(k), 64'd2);
    drain();
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", 64'({s, cout, ovf}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    directed(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, '{s: 32'h0000_0000, cout: 1'b1, ovf: 1'b0});
    directed(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, '{s: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0});
    directed(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{s: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1});
    directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, '{s: 32'h8000_0001, cout: 1'b0, ovf: 1'b1});

    // Back-to-back streaming: all corner pairs plus random beats.
    deliv_cyc.delete();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < 12; j++) begin
        logic ci = 1'($urandom_range(0, 1));
        logic op = 1'($urandom_range(0, 1));
        send(corners[i], corners[j], ci, op, model(corners[i], corners[j], ci, op));
        n++;
      end
    end
    for (int i = 0; i < 300; i++) begin
      send_rand();
      n++;
    end
    drain();
    check("stream_count", 64'(deliv_cyc.size()), 64'(n));
    if (deliv_cyc.size() == n)
      check("stream_throughput", 64'(deliv_cyc[n-1] - deliv_cyc[0]), 64'(n - 1));

    // Random downstream stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) send_rand();
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    // Backpressure with a full pipe of 0+0, 1+1, 2+2.
    send(32'd0, 32'd0, 1'b0, 1'b0, '{s: 32'd0, cout: 1'b0, ovf: 1'b0});
    send(32'd1, 32'd1, 1'b0, 1'b0, '{s: 32'd2, cout: 1'b0, ovf: 1'b0});
    send(32'd2, 32'd2, 1'b0, 1'b0, '{s: 32'd4, cout: 1'b0, ovf: 1'b0});
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_s", 64'(s), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("release_valid", 64'(out_valid), 64'd1);
      check("release_s", 64'(s), 64'(2 * i));
      @(posedge clk);
      #1;
    end
    drain();

    // Reset with two beats in flight plus a beat presented during reset.
    send($urandom, $urandom, 1'b0, 1'b0, '{s: '0, cout: 1'b0, ovf: 1'b0});
    send($urandom, $urandom, 1'b1, 1'b1, '{s: '0, cout: 1'b0, ovf: 1'b0});
    rst = 1'b1;
    a = 32'd3; b = 32'd4; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("flush_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    directed(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, '{s: 32'h0123_4566, cout: 1'b1, ovf: 1'b0});

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
